// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader and the instruction memory it feeds.
package inst_loader_pkg;

    localparam int unsigned DEFAULT_NUM_WORDS = 1024;
    localparam logic [31:0] NOP_INSN          = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Byte address of instruction word idx relative to base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Little-endian byte accumulator: bytes shift in from the top so the first byte
// of a group of four ends up in bits [7:0].
module byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        xfer_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  cnt_o,
    output logic [31:0] word_o,
    output logic        last_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;

    // Next-state for the byte counter and the shift accumulator; clear wins over a transfer.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clr_i) begin
            cnt_d = 2'd0;
            acc_d = 32'd0;
        end else if (xfer_i) begin
            cnt_d = cnt_q + 2'd1;
            acc_d = {byte_i, acc_q[31:8]};
        end else begin
            cnt_d = cnt_q;
            acc_d = acc_q;
        end
    end

    // Counter and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            acc_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign word_o = {byte_i, acc_q[31:8]};
    assign last_o = xfer_i && (cnt_q == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Streams a length-prefixed byte image into instruction memory, one 32-bit word
// per WRITE cycle, rejecting images longer than the memory.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned IDX_W        = $clog2(NUM_WORDS + 1);
    localparam logic [31:0] NUM_WORDS_32 = 32'(NUM_WORDS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_next_s;
    logic [15:0]        n_q, n_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               byte_ready_q, byte_ready_d;
    logic               mem_we_q, mem_we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               xfer_s;
    logic               asm_clr_s;
    logic [1:0]         asm_cnt_s;
    logic [31:0]        asm_word_s;
    logic               asm_last_s;
    logic               len_last_s;

    assign xfer_s     = byte_valid && byte_ready_q;
    assign idx_next_s = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
    assign len_last_s = (state_q == ST_LEN) && xfer_s && (asm_cnt_s == 2'd1);

    byte_assembler u_byte_assembler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (asm_clr_s),
        .xfer_i (xfer_s),
        .byte_i (byte_data),
        .cnt_o  (asm_cnt_s),
        .word_o (asm_word_s),
        .last_o (asm_last_s)
    );

    // Load sequencing: length header, word assembly, write strobes, completion.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        asm_clr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LEN;
                    idx_d     = '0;
                    asm_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (len_last_s) begin
                    // The counter is reused for data bytes, so restart it here.
                    n_d       = asm_word_s[31:16];
                    asm_clr_s = 1'b1;
                    if (asm_word_s[31:16] == 16'd0) begin
                        state_d = ST_DONE;
                    end else if ({16'd0, asm_word_s[31:16]} > NUM_WORDS_32) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (asm_last_s) begin
                    state_d     = ST_WRITE;
                    mem_wdata_d = asm_word_s;
                    mem_addr_d  = word_addr(BASE_ADDR, 32'(idx_q));
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                idx_d = idx_next_s;
                if (32'(idx_next_s) == {16'd0, n_q}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        byte_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA);
        mem_we_d     = (state_d == ST_WRITE);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            n_q          <= 16'd0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= NOP_INSN;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
